// File: rtl/led_ser_pkg.sv
// led_ser_pkg: shared widths, frame size, FSM state type and brightness scaling for the LED pixel serializer
package led_ser_pkg;

    localparam int PIX_W         = 16;
    localparam int PIX_PER_FRAME = 512;
    localparam int IDX_W         = 9;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    // (pix * (bright + 1)) >> 8 on a 16x9-bit product; bright = 255 returns pix unchanged
    function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] pix, input logic [7:0] bright);
        logic [PIX_W+8:0] prod;
        prod = {9'd0, pix} * ({{PIX_W{1'b0}}, 1'b0, bright} + (PIX_W+9)'(1));
        return PIX_W'(prod >> 8);
    endfunction

endpackage

// File: rtl/led_pixel_serializer_if.sv
// led_pixel_serializer_if: pixel word valid/ready handshake; carries bright when LED_SER_BRIGHTNESS_EN is defined
interface led_pixel_serializer_if;
    import led_ser_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
`ifdef LED_SER_BRIGHTNESS_EN
    logic [7:0]       bright;

    modport master (output pix_data, pix_valid, bright, input pix_ready);
    modport slave  (input pix_data, pix_valid, bright, output pix_ready);
`else
    modport master (output pix_data, pix_valid, input pix_ready);
    modport slave  (input pix_data, pix_valid, output pix_ready);
`endif

endinterface

// File: rtl/led_ser_shift_reg.sv
// led_ser_shift_reg: 16-bit load/shift-right register with bit counter; dout is bit 0, last_bit marks bit 15
module led_ser_shift_reg
    import led_ser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PIX_W-1:0] din,
    output logic             dout,
    output logic             last_bit
);

    logic [PIX_W-1:0] sr;
    logic [3:0]       bit_cnt;

    // load restarts the bit count; each shift pushes the next bit into position 0 (zeros fill from the top)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= din;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= sr >> 1;
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign dout     = sr[0];
    assign last_bit = bit_cnt == 4'd15;

endmodule

// File: rtl/led_pixel_serializer.sv
// led_pixel_serializer: serializes 16-bit pixel words LSB first on DAI/DEN with even-length DEN-low commit runs; optional LED_SER_BRIGHTNESS_EN scales words by bright
module led_pixel_serializer
    import led_ser_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                  DCK,
    input  logic                  rst,
    led_pixel_serializer_if.slave bus,
    output logic                  DAI,
    output logic                  DEN,
    output logic [IDX_W-1:0]      pix_idx,
    output logic                  frame_done
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_FRAME - 1);

    if (GAP_CYCLES < 2 || GAP_CYCLES % 2 != 0) begin : g_bad_gap
        $error("GAP_CYCLES must be even and at least 2");
    end

    state_t           state;
    logic [GW-1:0]    gap_cnt;
    logic             run_odd;
    logic             ready;
    logic             accept;
    logic             gap_last;
    logic             last_bit;
    logic [PIX_W-1:0] load_word;

    assign bus.pix_ready = ready;
    assign accept        = bus.pix_valid && ready;
    assign gap_last      = state == GAP && gap_cnt == GW'(GAP_CYCLES - 1);

`ifdef LED_SER_BRIGHTNESS_EN
    assign load_word = scale_pix(bus.pix_data, bus.bright);
`else
    assign load_word = bus.pix_data;
`endif

    led_ser_shift_reg u_shift (
        .clk      (DCK),
        .rst      (rst),
        .load     (accept),
        .shift    (state == SHIFT),
        .din      (load_word),
        .dout     (DAI),
        .last_bit (last_bit)
    );

    // Word framing FSM; run_odd is the parity of the DEN-low run counted through the current cycle,
    // so a word is only accepted where the run it closes is even
    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            DEN        <= 1'b0;
            ready      <= 1'b1;
            run_odd    <= 1'b0;
            gap_cnt    <= '0;
            pix_idx    <= LAST_IDX;
            frame_done <= 1'b0;
        end else begin
            frame_done <= gap_last && pix_idx == LAST_IDX;
            if (accept)
                pix_idx <= pix_idx == LAST_IDX ? '0 : pix_idx + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        DEN   <= 1'b1;
                        ready <= 1'b0;
                    end else begin
                        run_odd <= !run_odd;
                        ready   <= run_odd;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        state   <= GAP;
                        DEN     <= 1'b0;
                        gap_cnt <= '0;
                        ready   <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_last && accept) begin
                        state <= SHIFT;
                        DEN   <= 1'b1;
                        ready <= 1'b0;
                    end else if (gap_last) begin
                        state   <= IDLE;
                        run_odd <= 1'b1;
                        ready   <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        ready   <= gap_cnt == GW'(GAP_CYCLES - 2);
                    end
                end
                default: begin
                    state <= IDLE;
                    DEN   <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
